// File: rtl/phoenix_rom_loader_if.sv
// Purpose: bundles the hps_io download stream, the user reset request and the
//          loader's ROM write / status outputs into one port.
// Ports:   ioctl_* and user_reset flow master -> slave (loader);
//          wr_*, *_we, game_reset, load_done and load_err flow slave -> master.
interface phoenix_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        prog_we;
  logic        fg_we;
  logic        bg_we;
  logic        pal_we;
  logic        game_reset;
  logic        load_done;
  logic        load_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
    input  wr_addr, wr_data, prog_we, fg_we, bg_we, pal_we,
    input  game_reset, load_done, load_err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, user_reset,
    output wr_addr, wr_data, prog_we, fg_we, bg_we, pal_we,
    output game_reset, load_done, load_err
  );
endinterface

// File: rtl/phoenix_rom_loader.sv
// Purpose: decodes the linear ioctl ROM download into per-region write strobes,
//          checks the image length and owns the Phoenix game reset.
// Ports:   i_clk, i_reset (sync, active high); bus = loader side of
//          phoenix_rom_loader_if (ioctl stream in, ROM writes and status out).
//          A decoded write appears on wr_addr/wr_data/*_we one cycle after ioctl_wr.
module phoenix_rom_loader #(
  parameter logic [15:0] PROG_END    = 16'h4000,
  parameter logic [15:0] FG_END      = 16'h5000,
  parameter logic [15:0] BG_END      = 16'h6000,
  parameter logic [15:0] TOTAL_BYTES = 16'h6200,
  parameter int          RESET_HOLD  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  phoenix_rom_loader_if.slave   bus
);

  localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_cnt;
  logic [15:0] r_hold;
  logic        r_range_err;
  logic [13:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_prog_we;
  logic        r_fg_we;
  logic        r_bg_we;
  logic        r_pal_we;
  logic        r_game_reset;
  logic        r_load_done;
  logic        r_load_err;

  logic        w_sel_prog;
  logic        w_sel_fg;
  logic        w_sel_bg;
  logic        w_sel_pal;
  logic        w_out_of_range;
  logic [15:0] w_base;
  logic [13:0] w_rel_addr;
  logic        w_wr;
  logic        w_enter_load;

  // Region decode of the incoming byte address.
  always_comb begin
    w_sel_prog     = 1'b0;
    w_sel_fg       = 1'b0;
    w_sel_bg       = 1'b0;
    w_sel_pal      = 1'b0;
    w_out_of_range = 1'b0;
    w_base         = 16'h0000;
    if (bus.ioctl_addr < PROG_END) begin
      w_sel_prog = 1'b1;
    end else if (bus.ioctl_addr < FG_END) begin
      w_sel_fg = 1'b1;
      w_base   = PROG_END;
    end else if (bus.ioctl_addr < BG_END) begin
      w_sel_bg = 1'b1;
      w_base   = FG_END;
    end else if (bus.ioctl_addr < TOTAL_BYTES) begin
      w_sel_pal = 1'b1;
      w_base    = BG_END;
    end else begin
      w_out_of_range = 1'b1;
    end
  end

  assign w_rel_addr = 14'(bus.ioctl_addr - w_base);

  // Writes only count while in LOAD, including the one that lands on the
  // same edge as the download falling (state is still LOAD then).
  assign w_wr = (r_state == S_LOAD) && bus.ioctl_wr;

  // Any arrival in LOAD from another state starts a fresh image.
  assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.ioctl_download) w_next = S_LOAD;
      S_LOAD:  if (!bus.ioctl_download) w_next = S_CHECK;
      S_CHECK: w_next = ((r_cnt == TOTAL_BYTES) && !r_range_err) ? S_HOLD : S_ERR;
      S_HOLD: begin
        if (bus.ioctl_download)       w_next = S_LOAD;
        else if (r_hold == HOLD_LAST) w_next = S_RUN;
      end
      S_RUN:   if (bus.ioctl_download) w_next = S_LOAD;
      S_ERR:   if (bus.ioctl_download) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'h0000;
      r_hold       <= 16'h0000;
      r_range_err  <= 1'b0;
      r_wr_addr    <= 14'h0000;
      r_wr_data    <= 8'h00;
      r_prog_we    <= 1'b0;
      r_fg_we      <= 1'b0;
      r_bg_we      <= 1'b0;
      r_pal_we     <= 1'b0;
      r_game_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_prog_we <= w_wr && w_sel_prog;
      r_fg_we   <= w_wr && w_sel_fg;
      r_bg_we   <= w_wr && w_sel_bg;
      r_pal_we  <= w_wr && w_sel_pal;

      if (w_wr && !w_out_of_range) begin
        r_wr_addr <= w_rel_addr;
        r_wr_data <= bus.ioctl_dout;
      end

      if (w_enter_load) begin
        r_cnt       <= 16'h0000;
        r_range_err <= 1'b0;
      end else if (w_wr) begin
        if (w_out_of_range)
          r_range_err <= 1'b1;
        else if (r_cnt != 16'hFFFF)
          r_cnt <= r_cnt + 16'h0001;
      end

      // Counts cycles spent in HOLD; restarts whenever HOLD is (re)entered.
      if ((r_state == S_HOLD) && (w_next == S_HOLD))
        r_hold <= r_hold + 16'h0001;
      else
        r_hold <= 16'h0000;

      // In RUN the game reset follows user_reset one cycle late; every
      // other state keeps the core held.
      r_game_reset <= (w_next == S_RUN) ? bus.user_reset : 1'b1;
      r_load_done  <= (w_next == S_RUN);
      r_load_err   <= (w_next == S_ERR);
    end
  end

  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.prog_we    = r_prog_we;
  assign bus.fg_we      = r_fg_we;
  assign bus.bg_we      = r_bg_we;
  assign bus.pal_we     = r_pal_we;
  assign bus.game_reset = r_game_reset;
  assign bus.load_done  = r_load_done;
  assign bus.load_err   = r_load_err;

endmodule

// File: tb/tb_phoenix_rom_loader.sv
module tb_phoenix_rom_loader;

  localparam logic [15:0] TOTAL = 16'h6200;

  typedef struct {
    int          cyc;
    logic [3:0]  we;    // {pal, bg, fg, prog}
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb[$];
  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_prog = 0, n_fg = 0, n_bg = 0, n_pal = 0;
  int          probe_cyc = -1;
  logic        probe_bg = 1'b0;
  logic [13:0] probe_addr = '0;
  bit          exp_decode = 1'b0;
  logic [3:0]  mon_we;
  exp_t        mon_e;

  phoenix_rom_loader_if bus();

  phoenix_rom_loader dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Scoreboard side: every strobe must match the oldest expected write,
  // in the exact cycle it was predicted for.
  always @(negedge clk) begin
    mon_we = {bus.pal_we, bus.bg_we, bus.fg_we, bus.prog_we};
    if (cyc == probe_cyc) begin
      probe_bg   = bus.bg_we;
      probe_addr = bus.wr_addr;
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_strobe: got no strobe by cyc %0d, want we=%b addr=%h at cyc %0d",
               cyc, sb[0].we, sb[0].addr, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (mon_we !== 4'b0000) begin
      vectors++;
      if (mon_we[0] === 1'b1) n_prog++;
      if (mon_we[1] === 1'b1) n_fg++;
      if (mon_we[2] === 1'b1) n_bg++;
      if (mon_we[3] === 1'b1) n_pal++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got we=%b addr=%h at cyc %0d, want no strobe",
                 mon_we, bus.wr_addr, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_we !== mon_e.we || bus.wr_addr !== mon_e.addr ||
            bus.wr_data !== mon_e.data || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL strobe: got we=%b addr=%h data=%h cyc=%0d, want we=%b addr=%h data=%h cyc=%0d",
                   mon_we, bus.wr_addr, bus.wr_data, cyc,
                   mon_e.we, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic drive_write(input logic [15:0] a, input bit fall);
    exp_t        e;
    logic [15:0] rel;
    @(posedge clk); #1;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = pat(a);
    if (fall) bus.ioctl_download = 1'b0;
    if (exp_decode && a < TOTAL) begin
      if (a < 16'h4000)      begin e.we = 4'b0001; rel = a;            end
      else if (a < 16'h5000) begin e.we = 4'b0010; rel = a - 16'h4000; end
      else if (a < 16'h6000) begin e.we = 4'b0100; rel = a - 16'h5000; end
      else                   begin e.we = 4'b1000; rel = a - 16'h6000; end
      e.addr = rel[13:0];
      e.data = pat(a);
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    if (a == 16'h5003) probe_cyc = cyc + 1;
  endtask

  task automatic send_range(input int lo, input int hi, input bit fall_last);
    for (int a = lo; a <= hi; a++) drive_write(16'(a), fall_last && (a == hi));
  endtask

  task automatic start_dl();
    @(posedge clk); #1;
    bus.ioctl_download = 1'b1;
    exp_decode = 1'b1;
  endtask

  task automatic idle_slot(input bit drop);
    @(posedge clk); #1;
    bus.ioctl_wr = 1'b0;
    if (drop) bus.ioctl_download = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 16'h0000;
    bus.ioctl_dout     = 8'h00;
    bus.user_reset     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({bus.pal_we, bus.bg_we, bus.fg_we, bus.prog_we} !== 4'b0000) begin miscompares++; $display("FAIL reset_we: got %b want 0000", {bus.pal_we, bus.bg_we, bus.fg_we, bus.prog_we}); end
    vectors++; if (bus.wr_addr !== 14'h0000) begin miscompares++; $display("FAIL reset_wr_addr: got %h want 0000", bus.wr_addr); end
    vectors++; if (bus.wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
    vectors++; if (bus.game_reset !== 1'b1) begin miscompares++; $display("FAIL reset_game_reset: got %b want 1", bus.game_reset); end
    vectors++; if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done: got %b want 0", bus.load_done); end
    vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL reset_load_err: got %b want 0", bus.load_err); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.game_reset !== 1'b1) begin miscompares++; $display("FAIL idle_game_reset: got %b want 1", bus.game_reset); end
  endtask

  // Download that stops at 0x61FE: far fewer than 0x6200 bytes arrive.
  task automatic test_short_image();
    start_dl();
    send_range(32'h6000, 32'h61FE, 1'b0);
    idle_slot(1'b1);
    exp_decode = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL short_load_err: got %b want 1", bus.load_err); end
    vectors++; if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL short_load_done: got %b want 0", bus.load_done); end
    repeat (20) @(negedge clk);
    vectors++; if (bus.game_reset !== 1'b1) begin miscompares++; $display("FAIL short_game_reset: got %b want 1", bus.game_reset); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL short_pending: got %0d pending writes want 0", sb.size()); end
  endtask

  // Full image whose last byte (0x61FF) coincides with the download falling.
  task automatic test_full_image();
    int n;
    n_prog = 0; n_fg = 0; n_bg = 0; n_pal = 0;
    start_dl();
    send_range(32'h0000, 32'h61FF, 1'b1);
    @(posedge clk); #1;   // edge that decodes 0x61FF and moves LOAD -> CHECK
    bus.ioctl_wr = 1'b0;
    exp_decode = 1'b0;
    // Edge 1 leaves CHECK, edges 2..17 close the 16 HOLD cycles; RUN (and the
    // game_reset fall) arrives on edge 17, i.e. 16 cycles after CHECK.
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 5) begin
        vectors++; if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL hold_load_done: got %b want 0", bus.load_done); end
      end
      if (bus.game_reset === 1'b0) n = i;
    end
    vectors++; if (n != 17) begin miscompares++; $display("FAIL hold_length: got game_reset fall at edge %0d want 17", n); end
    vectors++; if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL run_load_done: got %b want 1", bus.load_done); end
    vectors++; if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL run_load_err: got %b want 0", bus.load_err); end
    vectors++; if (n_prog != 16384) begin miscompares++; $display("FAIL count_prog: got %0d want 16384", n_prog); end
    vectors++; if (n_fg != 4096) begin miscompares++; $display("FAIL count_fg: got %0d want 4096", n_fg); end
    vectors++; if (n_bg != 4096) begin miscompares++; $display("FAIL count_bg: got %0d want 4096", n_bg); end
    vectors++; if (n_pal != 512) begin miscompares++; $display("FAIL count_pal: got %0d want 512", n_pal); end
    vectors++; if (probe_bg !== 1'b1 || probe_addr !== 14'd3) begin miscompares++; $display("FAIL addr_5003: got bg_we=%b wr_addr=%h want 1 0003", probe_bg, probe_addr); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL full_pending: got %0d pending writes want 0", sb.size()); end
  endtask

  task automatic test_user_reset();
    bit [0:5] want_gr;
    want_gr = 6'b011100;
    @(posedge clk); #1 bus.user_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if (bus.game_reset !== want_gr[i]) begin miscompares++; $display("FAIL user_reset_%0d: got game_reset=%b want %b", i, bus.game_reset, want_gr[i]); end
      vectors++; if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL user_reset_done_%0d: got %b want 1", i, bus.load_done); end
      @(posedge clk); #1;
      if (i == 2) bus.user_reset = 1'b0;
    end
  endtask

  // Full image, abort 5 cycles into HOLD, then an image carrying a stray
  // write to 0x6200 inside the resulting LOAD.
  task automatic test_hold_abort_and_range();
    start_dl();
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.load_done !== 1'b0 || bus.game_reset !== 1'b1) begin miscompares++; $display("FAIL reload_status: got done=%b gr=%b want 0 1", bus.load_done, bus.game_reset); end
    send_range(32'h0000, 32'h61FF, 1'b0);
    idle_slot(1'b1);
    exp_decode = 1'b0;
    // LOAD->CHECK, CHECK->HOLD, then 5 HOLD cycles before the new download.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        vectors++; if (bus.game_reset !== 1'b1 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL hold_status: got gr=%b done=%b want 1 0", bus.game_reset, bus.load_done); end
      end
      @(posedge clk);
    end
    #1 bus.ioctl_download = 1'b1;
    exp_decode = 1'b1;
    send_range(32'h0000, 32'd29, 1'b0);
    @(negedge clk);
    vectors++; if (bus.game_reset !== 1'b1 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin miscompares++; $display("FAIL abort_status: got gr=%b done=%b err=%b want 1 0 0", bus.game_reset, bus.load_done, bus.load_err); end
    send_range(32'd30, 32'h2FFF, 1'b0);
    drive_write(16'h6200, 1'b0);
    send_range(32'h3000, 32'h61FF, 1'b0);
    idle_slot(1'b1);
    exp_decode = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL range_load_err: got %b want 1", bus.load_err); end
    repeat (20) @(negedge clk);
    vectors++; if (bus.game_reset !== 1'b1 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL range_status: got gr=%b done=%b want 1 0", bus.game_reset, bus.load_done); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL range_pending: got %0d pending writes want 0", sb.size()); end
  endtask

  task automatic test_reset_mid_load();
    start_dl();
    send_range(32'h1FF0, 32'h1FFF, 1'b0);
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.ioctl_addr = 16'h2000;
    bus.ioctl_dout = pat(16'h2000);
    @(posedge clk); #1;
    rst                = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    exp_decode         = 1'b0;
    @(negedge clk);
    vectors++; if ({bus.pal_we, bus.bg_we, bus.fg_we, bus.prog_we} !== 4'b0000) begin miscompares++; $display("FAIL midrst_we: got %b want 0000", {bus.pal_we, bus.bg_we, bus.fg_we, bus.prog_we}); end
    vectors++; if (bus.wr_addr !== 14'h0000 || bus.wr_data !== 8'h00) begin miscompares++; $display("FAIL midrst_wr: got addr=%h data=%h want 0000 00", bus.wr_addr, bus.wr_data); end
    vectors++; if (bus.game_reset !== 1'b1 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin miscompares++; $display("FAIL midrst_status: got gr=%b done=%b err=%b want 1 0 0", bus.game_reset, bus.load_done, bus.load_err); end
    for (int i = 0; i < 4; i++) drive_write(16'h0100 + 16'(i), 1'b0);
    idle_slot(1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL idle_pending: got %0d pending writes want 0", sb.size()); end
    vectors++; if (bus.game_reset !== 1'b1 || bus.load_done !== 1'b0) begin miscompares++; $display("FAIL idle_status: got gr=%b done=%b want 1 0", bus.game_reset, bus.load_done); end
  endtask

  initial begin
    test_reset();
    test_short_image();
    test_full_image();
    test_user_reset();
    test_hold_abort_and_range();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion by %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/phoenix_rom_loader.md
Name: phoenix_rom_loader

Overview:
Sequences the HPS ROM download stream into the Phoenix game's ROM and PROM memories and owns the game reset. It decodes the linear ioctl byte stream into per-region write strobes, checks the stream length, and holds the game in reset until a complete image is loaded plus a settle period. It sits between hps_io and the phoenix core, on the system clock.

Parameters:
PROG_END, 16'h4000, first byte address past the program ROM region (region 0x0000..PROG_END-1)
FG_END, 16'h5000, end of the foreground character ROM region (PROG_END..FG_END-1)
BG_END, 16'h6000, end of the background character ROM region (FG_END..BG_END-1)
TOTAL_BYTES, 16'h6200, end of the palette PROM region (BG_END..TOTAL_BYTES-1); required image size
RESET_HOLD, 16, number of clk cycles game_reset stays high after a good load

Ports:
clk  in  1  system clock (11 MHz domain)
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle byte write strobe
ioctl_addr  in  16  byte address of the current write
ioctl_dout  in  8  byte data
user_reset  in  1  OSD/button reset request
wr_addr  out  14  region-relative write address (region base subtracted)
wr_data  out  8  registered copy of ioctl_dout
prog_we  out  1  program ROM write strobe
fg_we  out  1  fg char ROM write strobe
bg_we  out  1  bg char ROM write strobe
pal_we  out  1  palette PROM write strobe
game_reset  out  1  reset to phoenix core
load_done  out  1  a valid image has been loaded
load_err  out  1  the last download was short, long or out of range

Behaviour:
- Reset values: all *_we=0, wr_addr=0, wr_data=0, game_reset=1, load_done=0, load_err=0, state=IDLE, byte counter=0, hold counter=0.
- States:
  - IDLE: game_reset=1. Goes to LOAD when ioctl_download=1.
  - LOAD: game_reset=1. Decodes writes. Goes to CHECK when ioctl_download falls.
  - CHECK: one cycle. Goes to HOLD if count==TOTAL_BYTES and no range error, else to ERR.
  - HOLD: game_reset=1. The hold counter counts RESET_HOLD cycles, then the block goes to RUN.
  - RUN: game_reset=user_reset, registered (1-cycle latency). load_done=1.
  - ERR: game_reset=1, load_err=1. Waits for the next ioctl_download=1, then goes to LOAD.
- Entering LOAD from any state:
  - Clears the byte counter, load_done, load_err and the range-error flag.
  - game_reset goes high on the same edge.
- Write decode (LOAD only; ioctl_wr is ignored in every other state):
  - Exactly one *_we pulses one cycle after ioctl_wr. wr_addr and wr_data are valid in that same cycle.
  - Region select is a strict compare of ioctl_addr against PROG_END, FG_END, BG_END and TOTAL_BYTES. wr_addr = ioctl_addr minus region base, truncated to 14 bits.
  - Address >= TOTAL_BYTES: no strobe, range-error flag set, byte counter not incremented.
  - Every in-range write increments the byte counter. The counter is 16 bits and saturates at 16'hFFFF.
- Back-to-back ioctl_wr on consecutive cycles produce consecutive strobes with no loss.
- ioctl_download falling in the same cycle as an ioctl_wr: that write is still decoded and counted before CHECK.
- ioctl_download rising during HOLD or RUN aborts the current state immediately to LOAD. load_done drops on the same edge.
- A reset pulse at any point returns the block to IDLE with all reset values. A partially loaded image is discarded, so a new download is required.

Test Plan:
- Full image (0x0000..0x61FF, one byte per cycle):
  - strobe counts: prog_we 16384, fg_we 4096, bg_we 4096, pal_we 512.
  - addr 0x5003 → bg_we with wr_addr=3.
  - CHECK → HOLD; game_reset falls exactly 16 cycles after CHECK; load_done=1, load_err=0.
- Short image (stop at 0x61FE) → ERR: load_err=1, game_reset stays 1.
  - A subsequent full download → RUN with load_err=0.
- Write to 0x6200 inside an otherwise full image → no strobe; load_err=1 after download ends.
- In RUN, user_reset pulse for 3 cycles → game_reset high for 3 cycles, delayed 1 cycle; load_done stays 1.
- ioctl_download rises 5 cycles into HOLD → LOAD; game_reset stays 1 and load_done stays 0.
  - Also: ioctl_wr coincident with the download falling edge at addr 0x61FF → pal_we pulses, count=0x6200, HOLD entered.
- reset asserted mid-LOAD at addr 0x2000 → IDLE, all outputs at reset values; ioctl_wr pulses while in IDLE produce no strobes.
